// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank: FSM encoding,
// command-byte field positions and the address range helper.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int   RW_BIT   = 7;
    localparam logic CMD_READ = 1'b1;

    // True when no address bit at or above addr_w is set
    function automatic logic addr_in_range(input logic [6:0] addr, input int unsigned addr_w);
        logic [6:0] high_bits;
        high_bits = addr >> addr_w;
        return (high_bits == 7'd0);
    endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchroniser for the raw chip select plus a registered
// rising-edge detect that marks the end of a frame.
module spi_cs_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic cs,
    output logic frame_end
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic frame_end_r;

    // Synchroniser chain; resets to the idle (deasserted, high) level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= cs;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // One-cycle pulse on the synchronised low-to-high transition
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_end_r <= 1'b0;
        end else begin
            frame_end_r <= sync_r & ~prev_r;
        end
    end

    assign frame_end = frame_end_r;

endmodule

// File: rtl/spi_reg_bank.sv
// Two-byte read/write command decoder and 8-bit register bank behind the SPI slave.
// Optional build macro SPI_REG_BURST_EN: consecutive data bytes write ascending addresses.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        NUM_REGS  = 2 ** ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  spi_cs,
    input  logic                  spi_data_ready,
    input  logic [7:0]            spi_rx_data,
    output logic                  spi_read_ack,
    output logic [7:0]            data_to_send,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  cmd_err
);

    state_t              state_r;
    state_t              next_state_s;
    logic                ack_q_r;
    logic                frame_end_s;
    logic                accept_s;
    logic                in_range_s;
    logic [ADDR_W-1:0]   cmd_addr_s;
    logic                do_read_s;
    logic                do_write_s;
    logic                do_err_s;
    logic                latch_addr_s;
    logic [ADDR_W-1:0]   wa_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                rd_valid_r;
    logic [7:0]          dts_r;
    logic                wr_strobe_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic                cmd_err_r;
    logic [7:0]          regs_r [NUM_REGS];

    spi_cs_sync u_cs_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .cs        (spi_cs),
        .frame_end (frame_end_s)
    );

    // The ack flop doubles as the consume guard: the slave keeps ready high
    // during the ack cycle, so a byte can't be taken while ack is asserted.
    assign accept_s   = spi_data_ready & ~ack_q_r;
    assign cmd_addr_s = spi_rx_data[ADDR_W-1:0];
    assign in_range_s = addr_in_range(spi_rx_data[6:0], ADDR_W);

    // FSM state register and acknowledge flop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ack_q_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ack_q_r <= accept_s;
        end
    end

    // Next-state and action decode; frame end overrides any accepted byte
    always_comb begin
        next_state_s = state_r;
        do_read_s    = 1'b0;
        do_write_s   = 1'b0;
        do_err_s     = 1'b0;
        latch_addr_s = 1'b0;
        if (frame_end_s) begin
            next_state_s = IDLE;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (!in_range_s) begin
                        do_err_s     = 1'b1;
                        next_state_s = DISCARD;
                    end else if (spi_rx_data[RW_BIT] == CMD_READ) begin
                        do_read_s    = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        latch_addr_s = 1'b1;
                        next_state_s = WR_DATA;
                    end
                end
                WR_DATA: begin
                    do_write_s = 1'b1;
`ifdef SPI_REG_BURST_EN
                    next_state_s = WR_DATA;
`else
                    next_state_s = DISCARD;
`endif
                end
                DISCARD: begin
                    next_state_s = DISCARD;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Write address: latched from the command, advanced per data byte in burst builds
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wa_r <= '0;
        end else if (latch_addr_s) begin
            wa_r <= cmd_addr_s;
`ifdef SPI_REG_BURST_EN
        end else if (do_write_s) begin
            wa_r <= wa_r + ADDR_W'(1);
`endif
        end
    end

    // Register bank storage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else if (do_write_s) begin
            regs_r[wa_r] <= spi_rx_data;
        end
    end

    // Transmit byte follows the last read address, including later writes to it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dts_r      <= 8'h00;
            rd_addr_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (do_read_s) begin
            dts_r      <= regs_r[cmd_addr_s];
            rd_addr_r  <= cmd_addr_s;
            rd_valid_r <= 1'b1;
        end else if (do_write_s && rd_valid_r && (rd_addr_r == wa_r)) begin
            dts_r <= spi_rx_data;
        end
    end

    // Write and error notification pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= '0;
            cmd_err_r   <= 1'b0;
        end else begin
            wr_strobe_r <= do_write_s;
            cmd_err_r   <= do_err_s;
            if (do_write_s) begin
                wr_addr_r <= wa_r;
            end
        end
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_flat
        assign reg_out[8*n +: 8] = regs_r[n];
    end

    assign spi_read_ack = ack_q_r;
    assign data_to_send = dts_r;
    assign wr_strobe    = wr_strobe_r;
    assign wr_addr      = wr_addr_r;
    assign cmd_err      = cmd_err_r;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: directed frames push expected writes and
// errors into queues; a negedge monitor pops and compares on each DUT pulse.
module tb_spi_reg_bank;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    logic                  clock;
    logic                  reset_n;
    logic                  spi_cs;
    logic                  spi_data_ready;
    logic [7:0]            spi_rx_data;
    logic                  spi_read_ack;
    logic [7:0]            data_to_send;
    logic [8*NUM_REGS-1:0] reg_out;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  cmd_err;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q [$];
    int         err_q [$];
    logic [7:0] exp_regs [NUM_REGS];
    logic [7:0] exp_dts;
    int         checks;
    int         errors;
    int         ack_cycles;
    int         bytes_sent;
    logic       ack_prev;

    spi_reg_bank #(.ADDR_W(ADDR_W), .RESET_VAL(8'h00)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .spi_cs         (spi_cs),
        .spi_data_ready (spi_data_ready),
        .spi_rx_data    (spi_rx_data),
        .spi_read_ack   (spi_read_ack),
        .data_to_send   (data_to_send),
        .reg_out        (reg_out),
        .wr_strobe      (wr_strobe),
        .wr_addr        (wr_addr),
        .cmd_err        (cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = exp_regs[i];
        return f;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Slave model: ready stays high through the ack cycle, drops one cycle later
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        spi_rx_data    = b;
        spi_data_ready = 1'b1;
        bytes_sent++;
        tick(1);
        while (!spi_read_ack && n < 50) begin
            tick(1);
            n++;
        end
        if (!spi_read_ack) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack for byte %0h", b);
        end
        tick(1);
        spi_data_ready = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        spi_cs = 1'b0;
        tick(4);
        if (n > 0) send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        tick(2);
        spi_cs = 1'b1;
        tick(10);
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
        exp_regs[a] = d;
    endtask

    // Monitor: pops scoreboard entries on each strobe/error pulse, checks ack width
    initial begin
        ack_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (wr_strobe) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got strobe addr %0d expected none", wr_addr);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 128'(wr_addr), 128'(e.addr));
                    check("wr_data", 128'(reg_out[8*e.addr +: 8]), 128'(e.data));
                end
            end
            if (cmd_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got cmd_err expected none");
                end else begin
                    void'(err_q.pop_front());
                end
            end
            if (spi_read_ack) ack_cycles++;
            if (spi_read_ack && ack_prev) begin
                checks++;
                errors++;
                $display("FAIL ack_width: got 2+ cycles expected 1");
            end
            ack_prev = spi_read_ack;
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        ack_cycles     = 0;
        bytes_sent     = 0;
        reset_n        = 1'b0;
        spi_cs         = 1'b1;
        spi_data_ready = 1'b0;
        spi_rx_data    = 8'h00;
        exp_dts        = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        check("rst_reg_out", reg_out, exp_flat());
        check("rst_dts", 128'(data_to_send), 128'(8'h00));
        check("rst_ack", 128'(spi_read_ack), 128'(1'b0));
        check("rst_wr_strobe", 128'(wr_strobe), 128'(1'b0));
        check("rst_cmd_err", 128'(cmd_err), 128'(1'b0));

        expect_write(4'd3, 8'hA5);
        send_frame(2, 8'h03, 8'hA5, 8'h00);
        check("wr3_bank", reg_out, exp_flat());
        check("wr3_ack_count", 128'(ack_cycles), 128'(2));

        send_frame(1, 8'h83, 8'h00, 8'h00);
        exp_dts = 8'hA5;
        check("rd3_dts", 128'(data_to_send), 128'(exp_dts));

        expect_write(4'd3, 8'h5A);
        send_frame(2, 8'h03, 8'h5A, 8'h00);
        exp_dts = 8'h5A;
        check("fresh_dts", 128'(data_to_send), 128'(exp_dts));

        err_q.push_back(1);
        send_frame(2, 8'h20, 8'hFF, 8'h00);
        check("oor_bank", reg_out, exp_flat());
        check("oor_dts", 128'(data_to_send), 128'(exp_dts));

        expect_write(4'd15, 8'h11);
`ifdef SPI_REG_BURST_EN
        expect_write(4'd0, 8'h22);
`endif
        send_frame(3, 8'h0F, 8'h11, 8'h22);
        check("burst_bank", reg_out, exp_flat());

        send_frame(1, 8'h05, 8'h00, 8'h00);
        err_q.push_back(2);
        send_frame(2, 8'h77, 8'h99, 8'h00);
        check("abort_bank", reg_out, exp_flat());

        expect_write(4'd7, 8'h77);
        send_frame(2, 8'h07, 8'h77, 8'h00);
        check("wr7_bank", reg_out, exp_flat());

        err_q.push_back(3);
        send_frame(1, 8'hA0, 8'h00, 8'h00);
        check("rd_oor_dts", 128'(data_to_send), 128'(exp_dts));

        send_frame(1, 8'h8F, 8'h00, 8'h00);
        exp_dts = 8'h11;
        check("rd15_dts", 128'(data_to_send), 128'(exp_dts));

        check("wr_q_empty", 128'(wr_q.size()), 128'(0));
        check("err_q_empty", 128'(err_q.size()), 128'(0));
        check("ack_total", 128'(ack_cycles), 128'(bytes_sent));

        spi_cs = 1'b0;
        tick(4);
        send_byte(8'h01);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        spi_cs  = 1'b1;
        tick(8);
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        check("midrst_bank", reg_out, exp_flat());
        check("midrst_dts", 128'(data_to_send), 128'(8'h00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
